// File: rtl/vec_stream_pkg.sv
// Shared types and default geometry for the vector stream transmitter.
package vec_stream_pkg;

  localparam int unsigned VecN  = 30;  // samples per vector
  localparam int unsigned VecT  = 11;  // signed sample width
  localparam int unsigned VecAw = 5;   // vector memory address width

  typedef logic signed [VecT-1:0] sample_t;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/vec_tx_fifo2.sv
// Two-entry register FIFO. The head entry and valid flag are registers, so the
// consumer sees no combinational path from its ready back to valid.
module vec_tx_fifo2 #(
  parameter int unsigned W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic signed [W-1:0] data_i,
  output logic signed [W-1:0] data_o,
  output logic                valid_o,
  output logic [1:0]          count_o
);

  logic signed [W-1:0] head_q, head_d;
  logic signed [W-1:0] tail_q, tail_d;
  logic [1:0]          count_q, count_d;
  logic                valid_q;
  logic                do_pop;
  logic                do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A full FIFO can still take a push in the same cycle as a pop.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = data_i;
        end else begin
          tail_d = data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry, count and output-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/vec_stream_tx.sv
// Vector stream transmitter: host-loaded N-sample memory streamed in address
// order over a valid/ready interface. Optional continuous repeat is enabled by
// defining VEC_TX_REPEAT_EN, which adds the repeat_mode input.
module vec_stream_tx
  import vec_stream_pkg::*;
#(
  parameter int unsigned N  = VecN,
  parameter int unsigned T  = VecT,
  parameter int unsigned AW = VecAw
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [T-1:0] wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic signed [T-1:0] m_data_out_x,
  output logic                m_valid_x,
  input  logic                m_ready_x
`ifdef VEC_TX_REPEAT_EN
  ,
  input  logic                repeat_mode
`endif
);

  // Read pointer carries one extra bit so it can sit at N once the pass is issued.
  localparam logic [AW:0]   PtrEnd  = (AW+1)'(N);
  localparam logic [AW:0]   PtrLast = (AW+1)'(N - 1);
  localparam logic [AW-1:0] CntLast = AW'(N - 1);

  state_t              state_q;
  logic                busy_q;
  logic [AW:0]         rd_ptr_q;
  logic [AW-1:0]       sent_q;
  logic                wrap_q;   // current pass has already wrapped into the next
  logic signed [T-1:0] mem [N];
  logic [1:0]          fifo_count;
  logic                wr_ok;
  logic                rd_issue;
  logic                hs;
  logic                rep_req;

`ifdef VEC_TX_REPEAT_EN
  assign rep_req = repeat_mode;
`else
  assign rep_req = 1'b0;
`endif

  assign wr_ok    = (state_q == IDLE) && wr_en && ({1'b0, wr_addr} < PtrEnd);
  // The read lands straight in the FIFO on the next edge, so the FIFO count
  // already accounts for every outstanding read.
  assign rd_issue = (state_q == STREAM) && (fifo_count < 2'd2) && (rd_ptr_q < PtrEnd);
  assign hs       = m_valid_x && m_ready_x;

  // Host write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  vec_tx_fifo2 #(
    .W (T)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_issue),
    .pop_i   (hs),
    .data_i  (mem[rd_ptr_q[AW-1:0]]),
    .data_o  (m_data_out_x),
    .valid_o (m_valid_x),
    .count_o (fifo_count)
  );

  // Control FSM: read pointer, handshake counter, wrap tracking and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      sent_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= STREAM;
            busy_q   <= 1'b1;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            wrap_q   <= 1'b0;
          end
        end
        STREAM: begin
          if (rd_issue) begin
            if ((rd_ptr_q == PtrLast) && rep_req) begin
              rd_ptr_q <= '0;
              wrap_q   <= 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
          if (hs) begin
            if (sent_q == CntLast) begin
              sent_q <= '0;
              if (wrap_q) begin
                wrap_q <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              sent_q <= sent_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  // done must coincide with the final handshake, so it follows m_ready_x.
  assign done = (state_q == STREAM) && hs && (sent_q == CntLast);

endmodule

// File: tb/tb_vec_stream_tx.sv
// Directed self-checking bench for vec_stream_tx.
module tb_vec_stream_tx;

  localparam int N  = 30;
  localparam int T  = 11;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic signed [T-1:0] wr_data = '0;
  logic                start = 1'b0;
  logic                m_ready_x = 1'b0;
  logic                busy;
  logic                done;
  logic                m_valid_x;
  logic signed [T-1:0] m_data_out_x;
`ifdef VEC_TX_REPEAT_EN
  logic                repeat_mode = 1'b0;
`endif

  int          tests = 0;
  int          errors = 0;
  int          exp_mem [N];
  logic [15:0] ready_pat = 16'b1001_0110_0011_1001;

  always #5 clk = ~clk;

  vec_stream_tx #(
    .N  (N),
    .T  (T),
    .AW (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x)
`ifdef VEC_TX_REPEAT_EN
    ,
    .repeat_mode  (repeat_mode)
`endif
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d[T-1:0];
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic start_cmd();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Modes: 0 ready high, 1 ready pattern, 2 start spam, 3 writes during stream,
  // 4 ready high with repeat_mode dropped in the third pass.
  task automatic run_pass(input int mode, input int nbeats, input bit expect_end);
    int beat, dones, ci, first_valid, last_hs_cyc, prev_data;
    bit prev_stall;
    beat = 0; dones = 0; ci = 0; first_valid = -1; last_hs_cyc = -1;
    prev_data = 0; prev_stall = 1'b0;
    while (beat < nbeats && ci < 4000) begin
      m_ready_x = (mode == 1) ? ready_pat[ci % 16] : 1'b1;
      start     = (mode == 2) && (ci % 5 == 0);
      if (mode == 3) begin
        wr_en   = 1'b1;
        wr_addr = (ci % 2 == 1) ? 5'd6 : 5'd5;
        wr_data = (ci % 2 == 1) ? 11'h3FF : 11'h400;
      end
`ifdef VEC_TX_REPEAT_EN
      if (mode == 4 && beat >= 65) repeat_mode = 1'b0;
`endif
      #1;
      check("busy_run", busy, 1);
      if (first_valid < 0 && m_valid_x) first_valid = ci;
      if (prev_stall) begin
        check("hold_valid", m_valid_x, 1);
        check("hold_data", m_data_out_x, prev_data);
      end
      if ((mode == 0 || mode == 4) && first_valid >= 0) check("no_gap", m_valid_x, 1);
      if (done) begin
        dones++;
        check("done_pos", (m_valid_x && m_ready_x) ? beat % N : -1, N - 1);
      end
      if (m_valid_x && m_ready_x) begin
        check("beat_data", m_data_out_x, exp_mem[beat % N]);
        beat++;
        last_hs_cyc = ci;
      end
      prev_stall = m_valid_x && !m_ready_x;
      prev_data  = m_data_out_x;
      cyc();
      ci++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    m_ready_x = 1'b0;
    check("beat_count", beat, nbeats);
    if (mode == 0) begin
      check("first_valid_cyc", first_valid, 1);
      check("last_hs_cyc", last_hs_cyc, N);
    end
    if (expect_end) begin
      check("done_count", dones, nbeats / N);
      #1;
      check("busy_end", busy, 0);
      check("valid_end", m_valid_x, 0);
    end
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid_x, 0);
    check("rst_data", m_data_out_x, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < N; i++) begin
      exp_mem[i] = i - 15;
      load(i, i - 15);
    end

    // Full-rate pass, then backpressured pass
    start_cmd();
    run_pass(0, N, 1'b1);
    start_cmd();
    run_pass(1, N, 1'b1);

    // Writes during streaming are ignored; writes in IDLE take effect
    start_cmd();
    run_pass(3, N, 1'b1);
    start_cmd();
    run_pass(0, N, 1'b1);
    load(5, -1024);
    load(6, 1023);
    exp_mem[5] = -1024;
    exp_mem[6] = 1023;
    start_cmd();
    run_pass(0, N, 1'b1);
    load(5, -10);
    load(6, -9);
    exp_mem[5] = -10;
    exp_mem[6] = -9;

    // Reset mid-stream abandons the vector; restart begins at addr 0
    start_cmd();
    run_pass(1, 12, 1'b0);
    reset = 1'b1;
    cyc();
    #1;
    check("mid_rst_valid", m_valid_x, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", m_data_out_x, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    cyc();
    start_cmd();
    run_pass(0, N, 1'b1);

    // Repeated start pulses while busy are ignored
    start_cmd();
    run_pass(2, N, 1'b1);

    // Simultaneous write and start: first beat sees the new data
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 11'sd77;
    start_cmd();
    wr_en = 1'b0;
    exp_mem[0] = 77;
    run_pass(0, N, 1'b1);

`ifdef VEC_TX_REPEAT_EN
    // Continuous repeat for three passes
    repeat_mode = 1'b1;
    start_cmd();
    run_pass(4, 3 * N, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
